// File: rtl/fast_pkg.sv
// Shared helpers for the FAST pipeline: address widths and stream geometry.
package fast_pkg;

    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

    function automatic int unsigned calc_bpc(input int unsigned patch_h,
                                             input int unsigned lanes);
        return patch_h / lanes;
    endfunction

    function automatic int unsigned calc_nstrip(input int unsigned row_num,
                                                input int unsigned patch_h,
                                                input int unsigned row_stride);
        return (row_num - patch_h) / row_stride + 1;
    endfunction

endpackage

// File: rtl/fast_col_assembler.sv
// Gathers the LANES-wide beats of one column into a full PATCH_H-tall column.
module fast_col_assembler
    import fast_pkg::*;
#(
    parameter int unsigned PATCH_H     = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              beat_valid_i,
    input  logic [clogb2(calc_bpc(PATCH_H, LANES))-1:0]       beat_idx_i,
    input  logic [LANES*PIXEL_WIDTH-1:0]                      beat_data_i,
    output logic [PATCH_H*PIXEL_WIDTH-1:0]                    col_o,
    output logic                                              col_done_o
);

    localparam int unsigned BPC     = calc_bpc(PATCH_H, LANES);
    localparam int unsigned BW      = clogb2(BPC);
    localparam int unsigned SLICE_W = LANES * PIXEL_WIDTH;

    logic last_beat;
    assign last_beat  = (beat_idx_i == BW'(BPC - 1));
    assign col_done_o = beat_valid_i && last_beat;

    // The final slice is taken straight from the bus so the column is complete on its last beat.
    if (BPC > 1) begin : g_store
        logic [(BPC-1)*SLICE_W-1:0] store_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                store_q <= '0;
            end else if (beat_valid_i && !last_beat) begin
                store_q[beat_idx_i*SLICE_W +: SLICE_W] <= beat_data_i;
            end
        end

        assign col_o = {beat_data_i, store_q};
    end else begin : g_direct
        assign col_o = beat_data_i;
    end

endmodule

// File: rtl/fast_patch_gen.sv
// Slides a PATCH_H x PATCH_W window along each strip and emits every full patch.
module fast_patch_gen
    import fast_pkg::*;
#(
    parameter int unsigned COL_NUM     = 640,
    parameter int unsigned ROW_NUM     = 480,
    parameter int unsigned PATCH_H     = 8,
    parameter int unsigned PATCH_W     = 7,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned ROW_STRIDE  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [LANES*PIXEL_WIDTH-1:0]           s_axis_tdata,
    input  logic [LANES*PIXEL_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                                   s_axis_tlast,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    output logic [PATCH_H*PATCH_W*PIXEL_WIDTH-1:0] m_patch,
    output logic [clogb2(COL_NUM)-1:0]             m_x,
    output logic [clogb2(ROW_NUM)-1:0]             m_y,
    output logic                                   m_eol,
    output logic                                   m_last,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   err
);

    localparam int unsigned BPC    = calc_bpc(PATCH_H, LANES);
    localparam int unsigned NSTRIP = calc_nstrip(ROW_NUM, PATCH_H, ROW_STRIDE);
    localparam int unsigned XW     = clogb2(COL_NUM);
    localparam int unsigned YW     = clogb2(ROW_NUM);
    localparam int unsigned BW     = clogb2(BPC);
    localparam int unsigned SW     = clogb2(NSTRIP);
    localparam int unsigned PIX    = PIXEL_WIDTH;
    localparam int unsigned WIN    = PATCH_H * PATCH_W * PIXEL_WIDTH;

    logic [BW-1:0]            beat_q, beat_d;
    logic [XW-1:0]            col_q, col_d;
    logic [SW-1:0]            strip_q, strip_d;
    logic [WIN-1:0]           win_q, win_d;
    logic [WIN-1:0]           m_patch_q;
    logic [XW-1:0]            m_x_q;
    logic [YW-1:0]            m_y_q;
    logic                     m_valid_q, m_eol_q, m_last_q, err_q;
    logic [PATCH_H*PIX-1:0]   col_data;
    logic                     col_done;
    logic                     acc, last_beat, last_col, last_strip, frame_end;
    logic                     early_last, shift, emit;

    assign s_axis_tready = rst_n && (!m_valid_q || m_ready);
    assign acc           = s_axis_tvalid && s_axis_tready;

    assign last_beat  = (beat_q == BW'(BPC - 1));
    assign last_col   = (col_q == XW'(COL_NUM - 1));
    assign last_strip = (strip_q == SW'(NSTRIP - 1));
    assign frame_end  = last_beat && last_col && last_strip;
    assign early_last = acc && s_axis_tlast && !frame_end;

    // A premature tlast aborts the frame, so its column must not reach the window or output.
    assign shift = col_done && !early_last;
    assign emit  = shift && (col_q >= XW'(PATCH_W - 1));

    fast_col_assembler #(
        .PATCH_H     (PATCH_H),
        .LANES       (LANES),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_col_asm (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .beat_valid_i (acc),
        .beat_idx_i   (beat_q),
        .beat_data_i  (s_axis_tdata),
        .col_o        (col_data),
        .col_done_o   (col_done)
    );

    always_comb begin
        beat_d  = beat_q;
        col_d   = col_q;
        strip_d = strip_q;
        if (acc) begin
            if (early_last) begin
                beat_d  = '0;
                col_d   = '0;
                strip_d = '0;
            end else if (last_beat) begin
                beat_d = '0;
                if (last_col) begin
                    col_d   = '0;
                    strip_d = last_strip ? '0 : strip_q + SW'(1);
                end else begin
                    col_d = col_q + XW'(1);
                end
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (shift) begin
            for (int unsigned r = 0; r < PATCH_H; r++) begin
                for (int unsigned c = 0; c + 1 < PATCH_W; c++) begin
                    win_d[(r*PATCH_W+c)*PIX +: PIX] = win_q[(r*PATCH_W+c+1)*PIX +: PIX];
                end
                win_d[(r*PATCH_W+PATCH_W-1)*PIX +: PIX] = col_data[r*PIX +: PIX];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            col_q     <= '0;
            strip_q   <= '0;
            win_q     <= '0;
            m_patch_q <= '0;
            m_x_q     <= '0;
            m_y_q     <= '0;
            m_valid_q <= 1'b0;
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            col_q   <= col_d;
            strip_q <= strip_d;
            win_q   <= win_d;
            // acc already implies the output slot is free, so emit never overwrites a held patch.
            if (emit) begin
                m_valid_q <= 1'b1;
                m_patch_q <= win_d;
                m_x_q     <= col_q - XW'(PATCH_W - 1);
                m_y_q     <= YW'(32'(strip_q) * ROW_STRIDE);
                m_eol_q   <= last_col;
                m_last_q  <= last_col && last_strip;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            err_q <= acc && (early_last || (frame_end && !s_axis_tlast) || !(&s_axis_tkeep));
        end
    end

    assign m_patch = m_patch_q;
    assign m_x     = m_x_q;
    assign m_y     = m_y_q;
    assign m_valid = m_valid_q;
    assign m_eol   = m_eol_q;
    assign m_last  = m_last_q;
    assign err     = err_q;

endmodule
